// File: rtl/seq_scan_ctrl.sv
// Frame-scan controller: serializes a parallel frame MSB-first into a
// 4-bit Moore pattern detector and counts matches per frame.
module seq_scan_ctrl #(
    parameter int FRAME_W = 14,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    input  logic [3:0]         pattern,
    input  logic               overlap,
    output logic               ser_x,
    output logic               z,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int IDX_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [3:0]         pat_q, pat_d;
    logic               ov_q, ov_d;
    logic [2:0]         hist_q, hist_d;
    logic [1:0]         fill_q, fill_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               z_q, z_d;

    logic [3:0] win;
    logic       hit;
    logic       load;

    assign ser_x     = (state_q == S_SHIFT) ? shreg_q[FRAME_W-1] : 1'b0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign z         = z_q;
    assign match_cnt = cnt_q;

    assign win = {hist_q, ser_x};
    assign hit = (fill_q == 2'd3) && (win == pat_q);
    // DONE also accepts so back-to-back frames lose no cycle
    assign load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        pat_d   = pat_q;
        ov_d    = ov_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        unique case (state_q)
            S_IDLE: begin
                z_d = 1'b0;
            end
            S_SHIFT: begin
                shreg_d = shreg_q << 1;
                idx_d   = idx_q + 1'b1;
                z_d     = hit;
                if (hit && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (hit && !ov_q) begin
                    hist_d = 3'b000;
                    fill_d = 2'd0;
                end else begin
                    hist_d = win[2:0];
                    fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
                end
                if (idx_q == IDX_W'(FRAME_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                z_d     = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load) begin
            shreg_d = frame;
            pat_d   = pattern;
            ov_d    = overlap;
            hist_d  = 3'b000;
            fill_d  = 2'd0;
            idx_d   = '0;
            cnt_d   = '0;
            z_d     = 1'b0;
            state_d = S_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            pat_q   <= '0;
            ov_q    <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            pat_q   <= pat_d;
            ov_q    <= ov_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl against a window-scan reference.
module tb_seq_scan_ctrl;

    localparam int FW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [FW-1:0] frame;
    logic [3:0]    pattern;
    logic          overlap;

    logic       ser_x, z, busy, done;
    logic [3:0] cnt;
    logic       ser_x3, z3, busy3, done3;
    logic [2:0] cnt3;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    bit zexp [0:FW+1];
    int nmatch;

    seq_scan_ctrl #(.FRAME_W(FW), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .frame(frame),
        .pattern(pattern), .overlap(overlap), .ser_x(ser_x),
        .z(z), .busy(busy), .done(done), .match_cnt(cnt)
    );

    seq_scan_ctrl #(.FRAME_W(FW), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .frame(frame),
        .pattern(pattern), .overlap(overlap), .ser_x(ser_x3),
        .z(z3), .busy(busy3), .done(done3), .match_cnt(cnt3)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: slide a 4-bit window over the frame; in non-overlap mode a
    // window may not start on or before the last matched bit.
    function automatic void model(input logic [FW-1:0] fr,
                                  input logic [3:0] p, input logic o);
        int last;
        logic [3:0] w;
        last   = -10;
        nmatch = 0;
        for (int i = 0; i <= FW + 1; i++) zexp[i] = 1'b0;
        for (int k = 3; k < FW; k++) begin
            w = {fr[FW-1-(k-3)], fr[FW-1-(k-2)], fr[FW-1-(k-1)], fr[FW-1-k]};
            if (w == p && (o || (k - 3) > last)) begin
                nmatch++;
                zexp[k+2] = 1'b1;
                last = k;
            end
        end
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        frame   = FW'($urandom);
        pattern = 4'($urandom);
        overlap = 1'($urandom);
    endtask

    // Entered in the cycle whose closing edge accepts the driven frame.
    task automatic scan(input int glitch, input int rstc, input bit hold,
                        input logic [FW-1:0] nf, input logic [3:0] np,
                        input logic no);
        logic [FW-1:0] fr;
        int exp_cnt;
        fr = frame;
        model(frame, pattern, overlap);
        exp_cnt = sat(nmatch, 15);
        for (int c = 1; c <= FW + 1; c++) begin
            step();
            chk($sformatf("ser_x c%0d", c), ser_x, (c <= FW) ? fr[FW-c] : 1'b0);
            chk($sformatf("z c%0d", c), z, zexp[c]);
            chk($sformatf("z3 c%0d", c), z3, zexp[c]);
            chk($sformatf("busy c%0d", c), busy, 1'b1);
            chk($sformatf("done c%0d", c), done, (c == FW + 1));
            chk($sformatf("done3 c%0d", c), done3, (c == FW + 1));
            if (c == FW + 1) begin
                chk("match_cnt", cnt, exp_cnt);
                chk("match_cnt3", cnt3, sat(nmatch, 7));
            end
            if (c == rstc) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("rst ser_x", ser_x, 0);
                chk("rst z", z, 0);
                chk("rst busy", busy, 0);
                chk("rst done", done, 0);
                chk("rst cnt", cnt, 0);
                chk("rst cnt3", cnt3, 0);
                return;
            end
            if (c == 1) begin
                if (!hold) start = 1'b0;
                junk();
            end
            if (c == glitch) start = 1'b1;
            if (c == glitch + 1 && !hold) start = 1'b0;
            if (c == FW + 1 && hold) begin
                frame   = nf;
                pattern = np;
                overlap = no;
            end
        end
        if (!hold) begin
            step();
            chk("idle busy", busy, 0);
            chk("idle done", done, 0);
            chk("idle z", z, 0);
            chk("idle ser_x", ser_x, 0);
            chk("idle cnt hold", cnt, exp_cnt);
        end
    endtask

    task automatic go(input logic [FW-1:0] f, input logic [3:0] p,
                      input logic o);
        frame   = f;
        pattern = p;
        overlap = o;
        start   = 1'b1;
        scan(0, 0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [FW-1:0] nf;
        logic [3:0]    np;
        logic          no;
        rst   = 1'b1;
        start = 1'b0;
        junk();
        step();
        step();
        rst = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset z", z, 0);
        chk("reset ser_x", ser_x, 0);
        chk("reset cnt", cnt, 0);

        go(14'h1B5A, 4'b1101, 1'b0);
        chk("tp nonov cnt", cnt, 2);
        go(14'h1B5A, 4'b1101, 1'b1);
        chk("tp ov cnt", cnt, 3);
        go(14'h0000, 4'b0000, 1'b1);
        chk("tp zero ov cnt", cnt, 11);
        chk("tp zero ov sat3", cnt3, 7);
        go(14'h0000, 4'b0000, 1'b0);
        chk("tp zero nonov cnt", cnt, 3);

        // start pulse mid-frame is ignored
        frame   = 14'h1B5A;
        pattern = 4'b1101;
        overlap = 1'b1;
        start   = 1'b1;
        scan(5, 0, 1'b0, '0, '0, 1'b0);
        chk("glitch cnt", cnt, 3);

        // reset in cycle 8 aborts with no done
        frame   = 14'h1B5A;
        pattern = 4'b1101;
        overlap = 1'b0;
        start   = 1'b1;
        scan(0, 8, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("abort no done", done, 0);
            chk("abort idle", busy, 0);
        end
        go(14'h1B5A, 4'b1101, 1'b0);
        chk("post-rst cnt", cnt, 2);

        // back-to-back with start held high
        junk();
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nf = FW'($urandom);
            np = 4'($urandom);
            no = 1'($urandom);
            scan(0, 0, (i < 4), nf, np, no);
        end

        for (int i = 0; i < 40; i++) begin
            nf = FW'($urandom);
            np = (i % 2 == 0) ? nf[FW-1-(i%4) -: 4] : 4'($urandom);
            no = 1'($urandom);
            go(nf, np, no);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
